// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit counter BHT merged with a tagged BTB, plus a sequential flush walker.
// Optional macro BPU_BYPASS_EN forwards a same-cycle update into the lookup path.
module branch_predict_unit #(
  parameter int          ENTRIES  = 32,
  parameter int          PC_W     = 32,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            start_n,
  input  logic [PC_W-1:0] pc_predict,
  output logic            take_branch,
  output logic            hit,
  output logic [PC_W-1:0] target_predict,
  input  logic            update,
  input  logic [PC_W-1:0] update_pc,
  input  logic            update_taken,
  input  logic            update_btb,
  input  logic [PC_W-1:0] update_target,
  input  logic            flush,
  output logic            busy
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   ptr_q, ptr_d;
  logic [ENTRIES-1:0][1:0]            ctr_q;
  logic [ENTRIES-1:0]                 valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]      tag_q;
  logic [ENTRIES-1:0][PC_W-1:0]       tgt_q;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [1:0]       u_ctr, ctr_upd_d;
  logic             upd_en, btb_wr;

  assign l_idx = pc_predict[IDX_W+1:2];
  assign l_tag = pc_predict[PC_W-1:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[PC_W-1:IDX_W+2];

  assign busy   = (state_q == S_FLUSH);
  assign upd_en = update && !busy;
  assign btb_wr = upd_en && update_taken && update_btb;
  assign u_ctr  = ctr_q[u_idx];

  always_comb begin
    ctr_upd_d = u_ctr;
    if (update_taken) begin
      if (u_ctr != 2'b11) ctr_upd_d = u_ctr + 2'd1;
    end else begin
      if (u_ctr != 2'b00) ctr_upd_d = u_ctr - 2'd1;
    end
  end

  // Lookup path; busy blanks everything so fetch never trusts a half-cleared table.
  always_comb begin
    take_branch    = ctr_q[l_idx][1];
    hit            = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    target_predict = tgt_q[l_idx];
`ifdef BPU_BYPASS_EN
    if (upd_en && (u_idx == l_idx)) begin
      take_branch = ctr_upd_d[1];
      if (btb_wr) begin
        hit            = (u_tag == l_tag);
        target_predict = update_target;
      end
    end
`endif
    if (busy) begin
      take_branch    = 1'b0;
      hit            = 1'b0;
      target_predict = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: if (flush) begin
        state_d = S_FLUSH;
        ptr_d   = '0;
      end
      S_FLUSH: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(ENTRIES-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]   <= CTR_INIT;
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (busy) begin
      valid_q[ptr_q] <= 1'b0;
      ctr_q[ptr_q]   <= CTR_INIT;
    end else if (upd_en) begin
      ctr_q[u_idx] <= ctr_upd_d;
      if (btb_wr) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= update_target;
      end
    end
  end
endmodule
